// File: rtl/ula_pkg.sv
// Shared ALU datapath definitions: divider FSM encoding, default width and the
// quotient value returned when dividing by zero.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Every quotient bit takes this value when the divisor is zero.
  localparam logic DIV0_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/ripple_subtractor.sv
// Ripple subtractor: a full-adder chain with b inverted and carry-in 1,
// so diff = a - b and borrow is the inverted final carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    full_adder u_fa (
      .a    (a[gi]),
      .b    (~b[gi]),
      .cin  (carry[gi]),
      .sum  (diff[gi]),
      .cout (carry[gi+1])
    );
  end

  assign borrow = ~carry[N];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results
// and a one-cycle done pulse after WIDTH iterations.
module seq_divider
  import ula_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             zero_reg;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_diff_msb;

  assign r_shift = {r_reg, q_reg[WIDTH-1]};

  ripple_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      (r_shift),
    .b      ({1'b0, d_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  // R < D keeps every restored partial remainder inside WIDTH bits, so the
  // top bit of the difference is zero whenever it is kept.
  assign unused_diff_msb = diff[WIDTH];
  assign r_next = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt_reg     <= '0;
      zero_reg    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg     <= dividend;
            d_reg     <= divisor;
            r_reg     <= '0;
            cnt_reg   <= '0;
            zero_reg  <= (divisor == '0);
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (zero_reg) begin
            // Divide by zero finishes after a single cycle with the dividend untouched.
            quotient    <= {WIDTH{DIV0_QUOTIENT_BIT}};
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state_reg   <= DONE;
          end else begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_CNT) begin
              quotient    <= q_next;
              remainder   <= r_next;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state_reg   <= DONE;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): results, done latency, busy handshake,
// start-while-busy, reset in flight, plus a seeded operand sweep.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int passed = 0;
  int lat;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Called just after the accepting edge; returns edges from accept to done.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!done && edges < 40);
  endtask

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] qe, input logic [W-1:0] re,
                        input logic ze, input int late);
    int edges;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(edges);
    check({tag, ".latency"}, 32'(edges), 32'(late));
    check({tag, ".q"}, 32'(quotient), 32'(qe));
    check({tag, ".r"}, 32'(remainder), 32'(re));
    check({tag, ".dz"}, 32'(div_by_zero), 32'(ze));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".hold"}, 32'(quotient), 32'(qe));
    $display("div %0d/%0d -> q=%0d r=%0d dz=%0d latency=%0d", a, b, quotient, remainder,
             div_by_zero, edges);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.q", 32'(quotient), 32'd0);
    check("reset.r", 32'(remainder), 32'd0);
    check("reset.dz", 32'(div_by_zero), 32'd0);

    // rst and start together: rst wins.
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start.busy", 32'(busy), 32'd0);

    do_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    do_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    do_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    do_div("42/0", 8'd42, 8'd0, 8'd255, 8'd42, 1'b1, 1);
    do_div("0/3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8);
    do_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);

    // start mid-RUN is ignored, then the held start is taken on the first idle edge.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore.latency", 32'(lat), 32'd8);
    check("ignore.q", 32'(quotient), 32'd14);
    check("ignore.r", 32'(remainder), 32'd2);
    $display("div 100/7 with mid-run start -> q=%0d r=%0d latency=%0d", quotient, remainder, lat);
    start = 1'b1;
    @(negedge clk);
    check("next.not_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("next.accepted", 32'(busy), 32'd1);
    wait_done(lat);
    check("next.latency", 32'(lat), 32'd8);
    check("next.q", 32'(quotient), 32'd66);
    check("next.r", 32'(remainder), 32'd2);
    $display("div 200/3 on first idle edge -> q=%0d r=%0d latency=%0d", quotient, remainder, lat);

    // Reset after three RUN iterations discards the operation.
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.q", 32'(quotient), 32'd0);
    check("midrst.r", 32'(remainder), 32'd0);
    check("midrst.dz", 32'(div_by_zero), 32'd0);
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) lat++;
    end
    check("midrst.no_done", 32'(lat), 32'd0);
    $display("reset mid-run -> busy=%0d q=%0d r=%0d", busy, quotient, remainder);
    do_div("200/13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 8);

    // Seeded operand sweep against integer division.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b, qe, re;
      a = W'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      qe = (b == 0) ? 8'hFF : a / b;
      re = (b == 0) ? a : a % b;
      do_div("sweep", a, b, qe, re, b == 0, (b == 0) ? 1 : 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
